// File: rtl/menu_pkg.sv
// Shared row/state encodings and the colour-step helper for the menu settings sequencer.
package menu_pkg;

  localparam logic [1:0] ROW_DIFF = 2'd0;
  localparam logic [1:0] ROW_R    = 2'd1;
  localparam logic [1:0] ROW_G    = 2'd2;
  localparam logic [1:0] ROW_B    = 2'd3;

  typedef enum logic {
    ST_MENU = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // One +/-1 step of the selected nibble; an all-black result is skipped so the snake stays visible.
  function automatic logic [11:0] step_color(input logic [11:0] color,
                                             input logic [1:0]  row,
                                             input logic        inc);
    logic [3:0]  nib;
    logic [11:0] res;
    case (row)
      ROW_R:   nib = color[11:8];
      ROW_G:   nib = color[7:4];
      default: nib = color[3:0];
    endcase
    nib = inc ? nib + 4'd1 : nib - 4'd1;
    res = color;
    case (row)
      ROW_R:   res[11:8] = nib;
      ROW_G:   res[7:4]  = nib;
      default: res[3:0]  = nib;
    endcase
    if (res == 12'h000) begin
      nib = inc ? nib + 4'd1 : nib - 4'd1;
      case (row)
        ROW_R:   res[11:8] = nib;
        ROW_G:   res[7:4]  = nib;
        default: res[3:0]  = nib;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/menu_settings_ctrl_if.sv
// Button/settings bundle between the front panel and the menu settings sequencer.
interface menu_settings_ctrl_if;
  logic        menu_active;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_enter;
  logic [1:0]  difficulty_level;
  logic [11:0] snake_color;
  logic [1:0]  sel_row;
  logic        game_start;
  logic        in_menu;

  modport master (
    output menu_active, btn_up, btn_down, btn_left, btn_right, btn_enter,
    input  difficulty_level, snake_color, sel_row, game_start, in_menu
  );

  modport slave (
    input  menu_active, btn_up, btn_down, btn_left, btn_right, btn_enter,
    output difficulty_level, snake_color, sel_row, game_start, in_menu
  );
endinterface

// File: rtl/menu_btn_edge.sv
// Rising-edge press detector for one debounced button level.
module menu_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic press_o
);

  logic prev_q;
  logic armed_q;

  // armed_q masks the first cycle after reset so a button held through reset is not a press
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign press_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/menu_settings_ctrl.sv
// Menu settings sequencer: row selection, difficulty and snake colour, game start pulse.
// Optional hold-to-repeat on left/right is built when MENU_AUTOREPEAT_EN is defined.
module menu_settings_ctrl
   import menu_pkg::*;
#(
   parameter logic [1:0]  DIFF_MAX      = 2'd3,
   parameter logic [1:0]  RESET_DIFF    = 2'd1,
   parameter logic [11:0] RESET_COLOR   = 12'h0F0,
   parameter logic [31:0] REPEAT_DELAY  = 32'd32_500_000,
   parameter logic [31:0] REPEAT_PERIOD = 32'd6_500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        menu_active,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_enter,
   output logic [1:0]  difficulty_level,
   output logic [11:0] snake_color,
   output logic [1:0]  sel_row,
   output logic        game_start,
   output logic        in_menu
);

   logic [5:0]  lvl;
   logic [5:0]  press;
   logic        up_p, down_p, left_p, right_p, enter_p, act_p;

   state_e      state_q, state_d;
   logic [1:0]  row_q, row_d;
   logic [1:0]  diff_q, diff_d;
   logic [11:0] color_q, color_d;
   logic        start_q, start_d;
   logic        in_menu_q, in_menu_d;

   logic        rpt_step;
   logic        rpt_inc;
   logic        step_inc;

   assign lvl = {menu_active, btn_enter, btn_right, btn_left, btn_down, btn_up};

   for (genvar i = 0; i < 6; i++) begin : g_edge
      menu_btn_edge u_edge (
         .clk     (clk),
         .rst_n   (rst_n),
         .level_i (lvl[i]),
         .press_o (press[i])
      );
   end

   assign {act_p, enter_p, right_p, left_p, down_p, up_p} = press;

`ifdef MENU_AUTOREPEAT_EN
   logic [31:0] hold_q, hold_d;
   logic        rep_q, rep_d;
   logic        hold_ok;

   // Counter arms on a left/right press; first repeat after REPEAT_DELAY, then every REPEAT_PERIOD
   always_comb begin
      hold_d   = 32'd0;
      rep_d    = 1'b0;
      rpt_step = 1'b0;
      hold_ok  = (state_q == ST_MENU) && (btn_left ^ btn_right) &&
                 !(enter_p | up_p | down_p);
      if (hold_ok) begin
         if (hold_q == 32'd0) begin
            hold_d = (left_p | right_p) ? 32'd1 : 32'd0;
         end else if (hold_q == (rep_q ? REPEAT_PERIOD : REPEAT_DELAY)) begin
            rpt_step = 1'b1;
            hold_d   = 32'd1;
            rep_d    = 1'b1;
         end else begin
            hold_d = hold_q + 32'd1;
            rep_d  = rep_q;
         end
      end
   end

   // Hold counter and repeat-phase registers, cleared on reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= 32'd0;
         rep_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         rep_q  <= rep_d;
      end
   end

   assign rpt_inc = btn_right;
`else
   assign rpt_step = 1'b0;
   assign rpt_inc  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_MENU;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: enter leaves MENU, a menu_active rising edge returns from PLAY
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_MENU: if (enter_p) state_d = ST_PLAY;
         ST_PLAY: if (act_p)   state_d = ST_MENU;
         default: state_d = ST_MENU;
      endcase
   end

   // Priority enter > vertical > horizontal; opposing pairs cancel and yield no action
   always_comb begin
      row_d     = row_q;
      diff_d    = diff_q;
      color_d   = color_q;
      start_d   = 1'b0;
      in_menu_d = (state_d == ST_MENU);
      step_inc  = (left_p ^ right_p) ? right_p : rpt_inc;
      if (state_q == ST_MENU) begin
         if (enter_p) begin
            start_d = 1'b1;
         end else if (up_p ^ down_p) begin
            row_d = up_p ? row_q - 2'd1 : row_q + 2'd1;
         end else if ((left_p ^ right_p) || rpt_step) begin
            if (row_q == ROW_DIFF) begin
               if (step_inc && (diff_q < DIFF_MAX)) begin
                  diff_d = diff_q + 2'd1;
               end else if (!step_inc && (diff_q != 2'd0)) begin
                  diff_d = diff_q - 2'd1;
               end
            end else begin
               color_d = step_color(color_q, row_q, step_inc);
            end
         end
      end
   end

   // Output/settings registers with reset values
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q     <= ROW_DIFF;
         diff_q    <= RESET_DIFF;
         color_q   <= RESET_COLOR;
         start_q   <= 1'b0;
         in_menu_q <= 1'b1;
      end else begin
         row_q     <= row_d;
         diff_q    <= diff_d;
         color_q   <= color_d;
         start_q   <= start_d;
         in_menu_q <= in_menu_d;
      end
   end

   assign difficulty_level = diff_q;
   assign snake_color      = color_q;
   assign sel_row          = row_q;
   assign game_start       = start_q;
   assign in_menu          = in_menu_q;

endmodule

// File: tb/tb_menu_settings_ctrl.sv
// Self-checking bench for menu_settings_ctrl: directed vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_menu_settings_ctrl;

   logic        clk;
   logic        rst_n;
   logic        menuActive;
   logic        btnUp;
   logic        btnDown;
   logic        btnLeft;
   logic        btnRight;
   logic        btnEnter;
   logic [1:0]  difficultyLevel;
   logic [11:0] snakeColor;
   logic [1:0]  selRow;
   logic        gameStart;
   logic        inMenu;
   int          testsRun;
   int          testsFailed;

   menu_settings_ctrl #(
      .REPEAT_DELAY  (32'd10),
      .REPEAT_PERIOD (32'd4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .menu_active      (menuActive),
      .btn_up           (btnUp),
      .btn_down         (btnDown),
      .btn_left         (btnLeft),
      .btn_right        (btnRight),
      .btn_enter        (btnEnter),
      .difficulty_level (difficultyLevel),
      .snake_color      (snakeColor),
      .sel_row          (selRow),
      .game_start       (gameStart),
      .in_menu          (inMenu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        up, down, left, right, enter;
      logic [1:0]  expDiff;
      logic [11:0] expColor;
      logic [1:0]  expRow;
   } vec_t;

   vec_t vecs[20];

   task automatic stepClk(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic u, input logic d, input logic l,
                                input logic r, input logic e);
      btnUp    = u;
      btnDown  = d;
      btnLeft  = l;
      btnRight = r;
      btnEnter = e;
      stepClk(1);
   endtask

   task automatic checkOutput(input string name, input logic [1:0] eDiff,
                              input logic [11:0] eColor, input logic [1:0] eRow,
                              input logic eMenu, input logic eStart);
      testsRun++;
      if (difficultyLevel !== eDiff || snakeColor !== eColor ||
          selRow !== eRow || inMenu !== eMenu || gameStart !== eStart) begin
         testsFailed++;
         $display("[TB] FAIL %s: got diff=%0d color=%h row=%0d in_menu=%b start=%b, want diff=%0d color=%h row=%0d in_menu=%b start=%b",
                  name, difficultyLevel, snakeColor, selRow, inMenu,
                  gameStart, eDiff, eColor, eRow, eMenu, eStart);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;

      //            up    down  left  right enter diff  color    row
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'h0F0, 2'd3};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 12'h0F0, 2'd0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 12'h0F0, 2'd0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 12'h0F0, 2'd0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 12'h0F0, 2'd0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 12'h0F0, 2'd0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 12'h0F0, 2'd1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 12'h0F0, 2'd2};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 12'h010, 2'd2};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 12'h0F0, 2'd2};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 12'h0F0, 2'd1};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 12'hFF0, 2'd1};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 12'hFF0, 2'd1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 12'hFF0, 2'd1};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 12'h0F0, 2'd1};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 12'h0F0, 2'd2};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 12'h0F0, 2'd3};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 12'h0FF, 2'd3};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 12'h0F0, 2'd3};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 12'h0F0, 2'd0};

      menuActive = 1'b1;
      btnUp      = 1'b0;
      btnDown    = 1'b0;
      btnLeft    = 1'b0;
      btnRight   = 1'b0;
      btnEnter   = 1'b0;

      // Reset with right already held: no press may be seen after release
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("reset", 2'd1, 12'h0F0, 2'd0, 1'b1, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("held_through_reset", 2'd1, 12'h0F0, 2'd0, 1'b1, 1'b0);
      stepClk(3);
      checkOutput("held_steady", 2'd1, 12'h0F0, 2'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Directed vector table: one press, check, release
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].up, vecs[i].down, vecs[i].left, vecs[i].right, vecs[i].enter);
         checkOutput($sformatf("vec%0d", i), vecs[i].expDiff, vecs[i].expColor, vecs[i].expRow,
                     1'b1, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Enter with right in the same cycle: only the start pulse
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("enter_pulse", 2'd2, 12'h0F0, 2'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pulse_one_cycle", 2'd2, 12'h0F0, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("play_ignores_buttons", 2'd2, 12'h0F0, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("play_ignores_enter", 2'd2, 12'h0F0, 2'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // menu_active rising edge returns to MENU with settings kept
      menuActive = 1'b0;
      stepClk(2);
      checkOutput("menu_active_low", 2'd2, 12'h0F0, 2'd0, 1'b0, 1'b0);
      menuActive = 1'b1;
      stepClk(1);
      checkOutput("menu_reenter", 2'd2, 12'h0F0, 2'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("menu_live_again", 2'd2, 12'h0F0, 2'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset while in PLAY
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      stepClk(1);
      checkOutput("reset_in_play", 2'd1, 12'h0F0, 2'd0, 1'b1, 1'b0);
      rst_n = 1'b1;
      stepClk(1);

`ifdef MENU_AUTOREPEAT_EN
      // Auto-repeat on row B with reset mid-hold
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("rpt_row_b", 2'd1, 12'h0F0, 2'd3, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("rpt_press", 2'd1, 12'h0F1, 2'd3, 1'b1, 1'b0);
      stepClk(9);
      checkOutput("rpt_before_delay", 2'd1, 12'h0F1, 2'd3, 1'b1, 1'b0);
      stepClk(1);
      checkOutput("rpt_first", 2'd1, 12'h0F2, 2'd3, 1'b1, 1'b0);
      stepClk(4);
      checkOutput("rpt_second", 2'd1, 12'h0F3, 2'd3, 1'b1, 1'b0);
      stepClk(4);
      checkOutput("rpt_third", 2'd1, 12'h0F4, 2'd3, 1'b1, 1'b0);
      stepClk(1);
      checkOutput("rpt_hold_end", 2'd1, 12'h0F4, 2'd3, 1'b1, 1'b0);
      rst_n = 1'b0;
      stepClk(1);
      checkOutput("rpt_reset", 2'd1, 12'h0F0, 2'd0, 1'b1, 1'b0);
      rst_n = 1'b1;
      stepClk(15);
      checkOutput("rpt_no_steps_after_reset", 2'd1, 12'h0F0, 2'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
